divider_seq: RTL

Multi-cycle integer divider completing the ALU datapath alongside the single-cycle add/sub/shift/compare/logic units. It accepts a dividend and divisor through a start/ready handshake and iterates one restoring-division step per clock. It returns quotient, remainder and the same four ALU flags (zero, negative, overflow, carry) so the ALU output mux can treat it as one more function unit. Supports unsigned and two's-complement signed operation.

---
 rtl/alu_pkg.sv | 18 +
 rtl/divider_seq_if.sv | 27 ++
 rtl/div_step.sv | 21 ++
 rtl/divider_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider FSM encoding and constants.
package alu_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_ITERS = WIDTH;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  // Most negative two's-complement value; the only signed dividend that can overflow.
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/divider_seq_if.sv
// Request/result bundle between the ALU issue logic and the sequential divider.
interface divider_seq_if import alu_pkg::*; ();

  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             zerof;
  logic             negf;
  logic             overf;
  logic             cout;

  modport master (
    output start, sgn, a, b,
    input  ready, done, quot, rem, zerof, negf, overf, cout
  );

  modport slave (
    input  start, sgn, a, b,
    output ready, done, quot, rem, zerof, negf, overf, cout
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step import alu_pkg::*; (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The true difference always fits in WIDTH+1 signed bits, so its MSB is the sign.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
module divider_seq import alu_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  divider_seq_if.slave bus
);

  div_state_t       state_reg, state_next;
  logic             sgn_reg;
  logic             qneg_reg;
  logic             rneg_reg;
  logic             ovf_reg;
  // Divide-by-zero in flight; its first DONE cycle registers the results.
  logic             zdiv_reg;
  logic [WIDTH-1:0] dvd_reg;   // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] dsr_reg;   // divisor magnitude
  logic [WIDTH-1:0] prem_reg;  // partial remainder
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             zerof_reg;
  logic             negf_reg;
  logic             overf_reg;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  div_step u_step (
    .rem_in  (prem_reg),
    .dvd_bit (dvd_reg[WIDTH-1]),
    .divisor (dsr_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign restoration of the magnitude result, with the signed-overflow result forced.
  always_comb begin
    q_fix = dvd_reg;
    r_fix = prem_reg;
    if (ovf_reg) begin
      q_fix = SMIN;
      r_fix = '0;
    end else if (sgn_reg) begin
      if (qneg_reg) q_fix = -dvd_reg;
      if (rneg_reg) r_fix = -prem_reg;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= DIV_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state_reg;
    bus.ready  = 1'b0;
    bus.done   = 1'b0;
    bus.cout   = 1'b0;
    case (state_reg)
      DIV_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_next = (bus.b == '0) ? DIV_DONE : DIV_RUN;
      end
      DIV_RUN: begin
        if (cnt_reg == CNT_W'(DIV_ITERS - 1)) state_next = DIV_FIX;
      end
      DIV_FIX: state_next = DIV_DONE;
      DIV_DONE: begin
        bus.done = ~zdiv_reg;
        if (!zdiv_reg) state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_reg   <= 1'b0;
      qneg_reg  <= 1'b0;
      rneg_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zdiv_reg  <= 1'b0;
      dvd_reg   <= '0;
      dsr_reg   <= '0;
      prem_reg  <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      zerof_reg <= 1'b0;
      negf_reg  <= 1'b0;
      overf_reg <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (bus.start) begin
            sgn_reg  <= bus.sgn;
            qneg_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rneg_reg <= bus.a[WIDTH-1];
            ovf_reg  <= bus.sgn && (bus.a == SMIN) && (bus.b == '1);
            zdiv_reg <= (bus.b == '0);
            prem_reg <= '0;
            cnt_reg  <= '0;
            dsr_reg  <= (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            // A zero divisor keeps the raw dividend: it is returned as the remainder.
            if (bus.b == '0)                     dvd_reg <= bus.a;
            else if (bus.sgn && bus.a[WIDTH-1])  dvd_reg <= -bus.a;
            else                                 dvd_reg <= bus.a;
          end
        end
        DIV_RUN: begin
          prem_reg <= step_rem;
          dvd_reg  <= {dvd_reg[WIDTH-2:0], step_q};
          cnt_reg  <= cnt_reg + 1'b1;
        end
        DIV_FIX: begin
          quot_reg  <= q_fix;
          rem_reg   <= r_fix;
          overf_reg <= ovf_reg;
          negf_reg  <= sgn_reg & q_fix[WIDTH-1];
          zerof_reg <= (q_fix == '0) & ~ovf_reg;
        end
        DIV_DONE: begin
          if (zdiv_reg) begin
            quot_reg  <= '1;
            rem_reg   <= dvd_reg;
            overf_reg <= 1'b1;
            negf_reg  <= 1'b0;
            zerof_reg <= 1'b0;
            zdiv_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quot  = quot_reg;
  assign bus.rem   = rem_reg;
  assign bus.zerof = zerof_reg;
  assign bus.negf  = negf_reg;
  assign bus.overf = overf_reg;

endmodule
